// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes the ALU result from the accepted operands and
// holds it in an output register backed by one skid entry. With the skid
// entry, upstream ready comes straight from a flop and never depends
// combinationally on downstream ready.
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_alu_control,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [TAGW-1:0] i_tag,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_illegal,
  output logic [TAGW-1:0] o_tag
);

  // One stored result. Flags and tag travel with the result, so a skid
  // entry reaches the output exactly as it was captured.
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [TAGW-1:0] tag;
  } entry_t;

  // EMPTY: nothing held. ONE: OUT valid. FULL: OUT and SKID valid.
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t          state;
  logic            out_valid;
  logic            skid_valid;
  logic            rdy_q;
  entry_t          out_ent;
  entry_t          skid_ent;
  entry_t          new_ent;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            accept;
  logic            drain;

  assign accept = i_valid & rdy_q;
  assign drain  = out_valid & i_ready;

  // ALU on the live inputs. Unused codes give a zero result and set the
  // illegal flag. Overflow wraps and does not trap.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (i_alu_control)
      3'b000:  alu_res = i_op_a + i_op_b;
      3'b001:  alu_res = i_op_a - i_op_b;
      3'b010:  alu_res = i_op_a & i_op_b;
      3'b011:  alu_res = i_op_a | i_op_b;
      3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      default: alu_ill = 1'b1;
    endcase
  end

  // Pack the entry that an accept would store.
  always_comb begin
    new_ent.result  = alu_res;
    new_ent.zero    = (alu_res == '0);
    new_ent.illegal = alu_ill;
    new_ent.tag     = i_tag;
  end

  // FSM and storage. Valids and ready are registered FSM outputs. Data
  // registers load only when they take a new entry and may hold stale
  // values while invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
      out_ent    <= '{result: '0, zero: 1'b1, illegal: 1'b0, tag: '0};
      skid_ent   <= '{result: '0, zero: 1'b1, illegal: 1'b0, tag: '0};
    end else if (i_flush) begin
      // Flush wins over a same-cycle accept. A same-cycle drain still
      // completes, because downstream sampled it at this edge.
      state      <= S_EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_ent   <= new_ent;
            out_valid <= 1'b1;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (drain && accept) begin
            out_ent <= new_ent;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end else if (accept) begin
            skid_ent   <= new_ent;
            skid_valid <= 1'b1;
            rdy_q      <= 1'b0;
            state      <= S_FULL;
          end
        end
        S_FULL: begin
          if (drain) begin
            out_ent    <= skid_ent;
            skid_valid <= 1'b0;
            rdy_q      <= 1'b1;
            state      <= S_ONE;
          end
        end
        default: begin
          state      <= S_EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          rdy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready   = rdy_q;
  assign o_valid   = out_valid;
  assign o_result  = out_ent.result;
  assign o_zero    = out_ent.zero;
  assign o_illegal = out_ent.illegal;
  assign o_tag     = out_ent.tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage. The reference model is a FIFO queue of
// expected results with at most two entries. Ready means fewer than two
// entries, and valid means at least one entry.
module tb_alu_exec_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_alu_control = 3'b000;
  logic [31:0] i_op_a = '0;
  logic [31:0] i_op_b = '0;
  logic [4:0]  i_tag = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_illegal;
  logic [4:0]  o_tag;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  alu_exec_stage #(.XLEN(32), .TAGW(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_control(i_alu_control), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .i_tag(i_tag), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_zero(o_zero), .o_illegal(o_illegal), .o_tag(o_tag)
  );

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        ill;
    logic [4:0]  t;
  } exp_t;

  exp_t mq[$];

  function automatic exp_t ref_op(logic [2:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    exp_t e;
    e.ill = 1'b0;
    case (c)
      3'd0: e.r = a + b;
      3'd1: e.r = a - b;
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd5: e.r = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      default: begin e.r = 32'd0; e.ill = 1'b1; end
    endcase
    e.z = (e.r == 32'd0);
    e.t = t;
    return e;
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit   acc, drn, fl;
    exp_t e;
    acc = i_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && i_ready;
    fl  = i_flush;
    e   = ref_op(i_alu_control, i_op_a, i_op_b, i_tag);
    @(posedge i_clk);
    if (fl) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic drive(logic v, logic [2:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    i_valid = v; i_alu_control = c; i_op_a = a; i_op_b = b; i_tag = t;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
    total++; if (o_result !== 32'd0 || o_zero !== 1'b1 || o_illegal !== 1'b0 || o_tag !== 5'd0) begin
      bad++; $display("FAIL reset_data got res=%h z=%b ill=%b tag=%0d want 0/1/0/0", o_result, o_zero, o_illegal, o_tag);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_alu();
    i_ready = 1'b1;
    drive(1, 3'b000, 32'hFFFF_FFFF, 32'd1, 5'd3); tick();
    total++; if (o_valid !== 1'b1 || o_result !== 32'd0 || o_zero !== 1'b1 || o_tag !== 5'd3) begin
      bad++; $display("FAIL alu_add_wrap got v=%b res=%h z=%b tag=%0d want 1/0/1/3", o_valid, o_result, o_zero, o_tag);
    end
    drive(1, 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd4); tick();
    total++; if (o_result !== 32'd1 || o_zero !== 1'b0 || o_tag !== 5'd4) begin
      bad++; $display("FAIL alu_slt got res=%h z=%b tag=%0d want 1/0/4", o_result, o_zero, o_tag);
    end
    drive(1, 3'b001, 32'd5, 32'd7, 5'd5); tick();
    total++; if (o_result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL alu_sub got=%h want=fffffffe", o_result); end
    drive(1, 3'b010, 32'hF0F0, 32'hFF00, 5'd6); tick();
    total++; if (o_result !== 32'hF000) begin bad++; $display("FAIL alu_and got=%h want=f000", o_result); end
    drive(1, 3'b011, 32'hF0F0, 32'hFF00, 5'd7); tick();
    total++; if (o_result !== 32'hFFF0 || o_valid !== 1'b1 || o_ready !== 1'b1) begin
      bad++; $display("FAIL alu_or got res=%h v=%b rdy=%b want fff0/1/1", o_result, o_valid, o_ready);
    end
    drive(0, 3'b000, 0, 0, 0); tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL alu_drain got=%b want=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    drive(1, 3'b000, 32'd1, 32'd0, 5'd1); tick();
    total++; if (o_ready !== 1'b1 || o_tag !== 5'd1) begin bad++; $display("FAIL b2b_first got rdy=%b tag=%0d want 1/1", o_ready, o_tag); end
    drive(1, 3'b000, 32'd2, 32'd0, 5'd2); tick();
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b want=0", o_ready); end
    drive(1, 3'b000, 32'd3, 32'd0, 5'd3); tick();
    total++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_tag !== 5'd1) begin
      bad++; $display("FAIL b2b_hold got rdy=%b v=%b tag=%0d want 0/1/1", o_ready, o_valid, o_tag);
    end
    i_ready = 1'b1; tick();
    total++; if (o_valid !== 1'b1 || o_tag !== 5'd2 || o_result !== 32'd2 || o_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_second got v=%b tag=%0d res=%0d rdy=%b want 1/2/2/1", o_valid, o_tag, o_result, o_ready);
    end
    tick();
    total++; if (o_valid !== 1'b1 || o_tag !== 5'd3 || o_result !== 32'd3) begin
      bad++; $display("FAIL b2b_third got v=%b tag=%0d res=%0d want 1/3/3", o_valid, o_tag, o_result);
    end
    drive(0, 3'b000, 0, 0, 0); tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", o_valid); end
  endtask

  task automatic test_illegal();
    i_ready = 1'b1;
    drive(1, 3'b110, 32'd7, 32'd9, 5'd10); tick();
    total++; if (o_result !== 32'd0 || o_illegal !== 1'b1 || o_zero !== 1'b1 || o_tag !== 5'd10) begin
      bad++; $display("FAIL illegal_code got res=%h ill=%b z=%b tag=%0d want 0/1/1/10", o_result, o_illegal, o_zero, o_tag);
    end
    drive(1, 3'b000, 32'd7, 32'd9, 5'd11); tick();
    total++; if (o_result !== 32'd16 || o_illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_clear got res=%0d ill=%b want 16/0", o_result, o_illegal);
    end
    drive(0, 3'b000, 0, 0, 0); tick();
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    drive(1, 3'b000, 32'd1, 32'd1, 5'd1); tick();
    drive(1, 3'b000, 32'd2, 32'd2, 5'd2); tick();
    drive(1, 3'b000, 32'd9, 32'd9, 5'd7); i_flush = 1'b1; tick();
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL flush_full got v=%b rdy=%b want 0/1", o_valid, o_ready);
    end
    // Flush from ONE with an accept that can really happen (ready=1).
    i_flush = 1'b0; drive(1, 3'b000, 32'd4, 32'd4, 5'd8); tick();
    drive(1, 3'b000, 32'd5, 32'd5, 5'd9); i_flush = 1'b1; tick();
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL flush_one got v=%b rdy=%b want 0/1", o_valid, o_ready);
    end
    i_flush = 1'b0; drive(0, 3'b000, 0, 0, 0); i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got v=%b tag=%0d want v=0", o_valid, o_tag); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    drive(1, 3'b000, 32'd1, 32'd1, 5'd1); tick();
    drive(1, 3'b000, 32'd2, 32'd2, 5'd2); tick();
    drive(0, 3'b000, 0, 0, 0);
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL arst_pre got rdy=%b want 0", o_ready); end
    #2 i_rst_n = 1'b0;
    #1;
    mq.delete();
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL arst_immediate got v=%b rdy=%b want 0/1", o_valid, o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    drive(1, 3'b000, 32'd10, 32'd20, 5'd9); tick();
    total++; if (o_valid !== 1'b1 || o_result !== 32'd30 || o_tag !== 5'd9) begin
      bad++; $display("FAIL arst_after got v=%b res=%0d tag=%0d want 1/30/9", o_valid, o_result, o_tag);
    end
    drive(0, 3'b000, 0, 0, 0); tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h8000_0000; pool[5] = 32'h5;
    for (int n = 0; n < 400; n++) begin
      i_valid       = ($urandom_range(0, 3) != 0);
      i_ready       = ($urandom_range(0, 2) != 0);
      i_flush       = ($urandom_range(0, 19) == 0);
      i_alu_control = 3'($urandom_range(0, 7));
      i_op_a        = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : $urandom;
      i_op_b        = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : $urandom;
      i_tag         = 5'($urandom);
      tick();
      total++;
      if (o_valid !== (mq.size() > 0) || o_ready !== (mq.size() < 2)) begin
        bad++; $display("FAIL rand_hs cyc=%0d got v=%b rdy=%b want v=%b rdy=%b", n, o_valid, o_ready, mq.size() > 0, mq.size() < 2);
      end else if (mq.size() > 0) begin
        if (o_result !== mq[0].r || o_zero !== mq[0].z || o_illegal !== mq[0].ill || o_tag !== mq[0].t) begin
          bad++;
          $display("FAIL rand_data cyc=%0d got res=%h z=%b ill=%b tag=%0d want res=%h z=%b ill=%b tag=%0d",
                   n, o_result, o_zero, o_illegal, o_tag, mq[0].r, mq[0].z, mq[0].ill, mq[0].t);
        end
      end
    end
    i_flush = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute stage placed directly downstream of the ALU control decoder. It accepts two operands, the 3-bit ALU control code and a destination tag through a valid/ready handshake. It computes the ALU result and registers it with a one-cycle latency. A 2-entry skid buffer lets the input ready signal be a pure register output, so upstream never stalls combinationally on downstream ready.

Parameters:
XLEN, 32, operand/result width in bits
TAGW, 5, destination-register tag width

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream presents an operation
o_ready  output  1  stage can accept; registered, depends only on state
i_alu_control  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
i_op_a  input  XLEN  operand A
i_op_b  input  XLEN  operand B
i_tag  input  TAGW  destination tag, passed through unchanged
i_flush  input  1  synchronous kill of all in-flight entries
o_valid  output  1  result available
i_ready  input  1  downstream accepts result
o_result  output  XLEN  ALU result
o_zero  output  1  o_result == 0
o_illegal  output  1  captured control code was 100, 110 or 111
o_tag  output  TAGW  tag of o_result

Behaviour:
- Reset (async assert, sync-to-clock release): out_valid=0, skid_valid=0, o_ready=1, o_result=0, o_tag=0, o_zero=1, o_illegal=0.
- Accept: i_valid & o_ready at a rising edge. Drain: o_valid & i_ready at a rising edge.
- ALU (combinational on inputs, captured at accept): ADD a+b mod 2^XLEN; SUB a-b mod 2^XLEN; AND; OR; SLT = signed(a)<signed(b) ? 1 : 0, zero-extended. Codes 100/110/111 give result 0 and illegal=1. Overflow is ignored, no trap.
- The o_zero/o_illegal/o_tag fields are stored together with the result in each entry.
- Latency: an operation accepted at edge N shows o_valid=1 after edge N, provided the output register is free or draining at edge N.
- Storage: output register (OUT) plus skid register (SKID). o_ready = !skid_valid.
- State FSM: EMPTY (out 0, skid 0), ONE (out 1, skid 0), FULL (out 1, skid 1).
- In EMPTY: accept loads OUT and moves to ONE.
- In ONE, with drain and accept: OUT is reloaded and stays in ONE.
- In ONE, with drain and no accept: moves to EMPTY.
- In ONE, with accept and no drain: new entry goes into SKID and moves to FULL.
- In FULL (o_ready=0, no accept possible): drain moves SKID to OUT and returns to ONE.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- i_flush: both valids are cleared at the edge and the state becomes EMPTY. Flush beats a same-cycle accept, and the accepted data is discarded. A same-cycle drain still counts as a completed transfer downstream. o_ready is 1 after the edge.
- Data registers keep stale values when invalid; only o_valid qualifies them.
- Reset mid-operation discards all entries immediately.

Test Plan:
- ADD 0xFFFFFFFF+1, tag 3, i_ready=1 -> next cycle o_valid=1, o_result=0, o_zero=1, o_tag=3.
- SLT a=0xFFFFFFFF (−1), b=1 -> o_result=1. SUB 5-7 -> 0xFFFFFFFE. AND 0xF0F0&0xFF00 -> 0xF000. OR -> 0xFFF0.
- i_ready=0, issue 3 ops (tags 1,2,3) back-to-back -> tags 1 and 2 are accepted and o_ready=0 after the second accept. Then raise i_ready -> tags 1,2,3 emerge in order, with no bubble between 1 and 2.
- Code 3'b110, a=7, b=9 -> o_result=0, o_illegal=1; the following valid ADD clears o_illegal.
- FULL state plus i_flush with a same-cycle i_valid -> next cycle o_valid=0, o_ready=1, and the flushed op never appears.
- Assert i_rst_n=0 asynchronously mid-stream while FULL -> o_valid=0 and o_ready=1 without waiting for a clock edge; the first op after release returns correctly.
